mem_access_stage: RTL

- Memory stage placed directly downstream of execute in the 16-bit processor.
- Takes the execute-stage ALU result as the byte address and the second register operand as store data.
- Runs a multi-cycle handshake with a stallable data memory and holds the upstream pipeline with Stall until the access completes.
- Flags misaligned accesses, illegal op combinations and memory timeouts on a sticky error output.

---
 rtl/mem_access_stage.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage of the 16-bit pipeline.
// Latches the execute-stage address/store data, runs the ISSUE/WAIT handshake
// with a stallable data memory, holds the upstream pipeline with Stall, and
// keeps a sticky Err for misaligned, illegal and timed-out accesses.
module mem_access_stage #(
   parameter int TIMEOUT = 15,
   parameter int CW      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ALUOut,
   input  logic [15:0] WriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [15:0] mem_DataOut,
   input  logic        mem_Stall,
   input  logic        mem_Done,
   output logic [15:0] mem_Addr,
   output logic [15:0] mem_DataIn,
   output logic        mem_Rd,
   output logic        mem_Wr,
   output logic [15:0] MemOut,
   output logic        Stall,
   output logic        Err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Last WAIT count before the access is abandoned, and the saturation ceiling.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   addr_q, addr_d;
   logic [15:0]   data_q, data_d;
   logic          wr_q, wr_d;        // latched op: 1 = store, 0 = load
   logic [15:0]   memout_q, memout_d;
   logic          err_q, err_d;

   logic          req_s;
   logic          illegal_s;
   logic          misalign_s;
   logic          valid_req_s;

   assign req_s       = MemRead | MemWrite;
   assign illegal_s   = MemRead & MemWrite;
   assign misalign_s  = req_s & ALUOut[0];
   assign valid_req_s = req_s & ~illegal_s & ~ALUOut[0];

   // Next-state, latch and result computation for the access handshake.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wr_d     = wr_q;
      memout_d = memout_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (illegal_s) begin
               err_d = 1'b1;
            end else if (misalign_s) begin
               err_d = 1'b1;
            end else if (valid_req_s) begin
               addr_d  = ALUOut;
               data_d  = WriteData;
               wr_d    = MemWrite;
               state_d = S_ISSUE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (mem_Stall) begin
               state_d = S_ISSUE;
            end else if (mem_Done) begin
               if (!wr_q) begin
                  memout_d = mem_DataOut;
               end else begin
                  memout_d = memout_q;
               end
               state_d = S_DONE;
            end else begin
               cnt_d   = CNT_ZERO;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_Done) begin
               if (!wr_q) begin
                  memout_d = mem_DataOut;
               end else begin
                  memout_d = memout_q;
               end
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               err_d = 1'b1;
               if (!wr_q) begin
                  memout_d = 16'h0000;
               end else begin
                  memout_d = memout_q;
               end
               state_d = S_DONE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_ONE;
            end else begin
               cnt_d = cnt_q;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and latch registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= CNT_ZERO;
         addr_q   <= 16'h0000;
         data_q   <= 16'h0000;
         wr_q     <= 1'b0;
         memout_q <= 16'h0000;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         wr_q     <= wr_d;
         memout_q <= memout_d;
         err_q    <= err_d;
      end
   end

   // Memory strobes, address/data and pipeline stall; forced idle while in reset.
   always_comb begin
      mem_Rd     = 1'b0;
      mem_Wr     = 1'b0;
      Stall      = 1'b0;
      mem_Addr   = 16'h0000;
      mem_DataIn = 16'h0000;
      if (rst) begin
         Stall = 1'b0;
      end else begin
         mem_Addr   = addr_q;
         mem_DataIn = data_q;
         case (state_q)
            S_IDLE: begin
               Stall = valid_req_s;
            end
            S_ISSUE: begin
               Stall  = 1'b1;
               mem_Rd = ~wr_q;
               mem_Wr = wr_q;
            end
            S_WAIT: begin
               Stall = 1'b1;
            end
            S_DONE: begin
               Stall = 1'b0;
            end
            default: begin
               Stall = 1'b0;
            end
         endcase
      end
   end

   assign MemOut = memout_q;
   assign Err    = err_q;

endmodule
